// File: rtl/gf_p_pkg.sv
// Shared GF(p) field-arithmetic constants and types, p = 2^255 - 19.
package gf_p_pkg;

  localparam int WIDTH     = 256;
  localparam int LIMB_W    = 64;
  localparam int NUM_LIMBS = WIDTH / LIMB_W;
  localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  // p = 2^255 - 19 = 0x7FFF...FFED: bit 255 clear, bits 254..5 set, low bits 5'b01101.
  localparam logic [WIDTH-1:0] MODULUS = {1'b0, {(WIDTH-6){1'b1}}, 5'b01101};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CORR = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/limb_addsub.sv
// Combinational one-limb adder/subtractor shared by the subtract and correction passes.
module limb_addsub
  import gf_p_pkg::*;
(
  input  logic              mode,  // 0 = add, 1 = subtract
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic              cin,   // carry-in (add) or borrow-in (sub)
  output logic [LIMB_W-1:0] r,
  output logic              cout   // carry-out (add) or borrow-out (sub)
);

  logic [LIMB_W:0] x_ext;
  logic [LIMB_W:0] y_ext;
  logic [LIMB_W:0] c_ext;
  logic [LIMB_W:0] sum;

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};
  assign c_ext = {{LIMB_W{1'b0}}, cin};

  // One extra bit captures the carry; in subtract mode it goes high on wrap, i.e. a borrow.
  always_comb begin
    if (mode) sum = x_ext - y_ext - c_ext;
    else      sum = x_ext + y_ext + c_ext;
  end

  assign r    = sum[LIMB_W-1:0];
  assign cout = sum[LIMB_W];

endmodule

// File: rtl/gf_p_subtractor.sv
// Limb-serial modular subtractor: diff = (a - b) mod p, one 64-bit limb per cycle,
// followed by an always-executed +p pass so latency is fixed at 10 cycles.
module gf_p_subtractor
  import gf_p_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff
);

  localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NUM_LIMBS - 1);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic [WIDTH-1:0]  d_sr;
  logic [WIDTH-1:0]  c_sr;
  logic              borrow;
  logic              carry;
  logic              need_corr;

  logic              au_mode;
  logic [LIMB_W-1:0] au_x;
  logic [LIMB_W-1:0] au_y;
  logic              au_cin;
  logic [LIMB_W-1:0] au_r;
  logic              au_cout;
  logic              last_limb;

  assign last_limb = (cnt == LAST_LIMB);

  limb_addsub u_limb (
    .mode (au_mode),
    .x    (au_x),
    .y    (au_y),
    .cin  (au_cin),
    .r    (au_r),
    .cout (au_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state, busy, and steering of the shared limb unit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    next_state = state;
    busy       = 1'b0;
    au_mode    = 1'b1;
    au_x       = a_sr[LIMB_W-1:0];
    au_y       = b_sr[LIMB_W-1:0];
    au_cin     = borrow;
    unique case (state)
      IDLE: if (start) next_state = SUB;
      SUB: begin
        busy = 1'b1;
        if (last_limb) next_state = CORR;
      end
      CORR: begin
        busy    = 1'b1;
        au_mode = 1'b0;
        au_x    = d_sr[LIMB_W-1:0];
        au_y    = MODULUS[cnt*LIMB_W +: LIMB_W];
        au_cin  = carry;
        if (last_limb) next_state = FIN;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, limb shifting, borrow/carry chains and result register.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so an aborted operation leaves no stale result.
    if (reset) begin
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      d_sr      <= '0;
      c_sr      <= '0;
      borrow    <= 1'b0;
      carry     <= 1'b0;
      need_corr <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
          end
        end
        SUB: begin
          a_sr   <= a_sr >> LIMB_W;
          b_sr   <= b_sr >> LIMB_W;
          d_sr   <= {au_r, d_sr[WIDTH-1:LIMB_W]};
          borrow <= au_cout;
          cnt    <= cnt + CNT_W'(1);
          if (last_limb) need_corr <= au_cout;
        end
        CORR: begin
          // d is rotated rather than shifted so it is intact again for FIN.
          d_sr  <= {d_sr[LIMB_W-1:0], d_sr[WIDTH-1:LIMB_W]};
          c_sr  <= {au_r, c_sr[WIDTH-1:LIMB_W]};
          carry <= au_cout;
          cnt   <= cnt + CNT_W'(1);
        end
        FIN: begin
          diff <= need_corr ? c_sr : d_sr;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_p_subtractor.sv
// Directed self-checking bench for gf_p_subtractor.
module tb_gf_p_subtractor;

  typedef logic [255:0] word_t;

  localparam word_t P = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

  logic  clk;
  logic  reset;
  logic  start;
  word_t a;
  word_t b;
  logic  busy;
  logic  done;
  word_t diff;

  int n_checks = 0;
  int n_pass   = 0;

  gf_p_subtractor dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  function automatic word_t bit1(input logic v);
    return {255'b0, v};
  endfunction

  // One full operation; the accept edge is edge 0, done is expected after edge 9.
  task automatic run_op(input string tag, input word_t av, input word_t bv, input word_t exp);
    int lat;
    bit got_done;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv;  // captured operands must not follow the inputs
    got_done = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && !got_done; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done) begin
        got_done = 1'b1;
        lat = k;
      end else begin
        check({tag, "_busy"}, bit1(busy), bit1(k <= 7));
      end
    end
    check({tag, "_done_seen"}, bit1(got_done), bit1(1'b1));
    check({tag, "_latency"}, word_t'(lat), word_t'(9));
    check({tag, "_diff"}, diff, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bit1(done), bit1(1'b0));
    check({tag, "_diff_hold"}, diff, exp);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bit1(busy), bit1(1'b0));
    check("rst_done", bit1(done), bit1(1'b0));
    check("rst_diff", diff, '0);
    reset = 1'b0;

    run_op("5m3", 256'd5, 256'd3, 256'd2);
    run_op("3m5", 256'd3, 256'd5, P - 256'd2);
    run_op("eq", 256'h1234_5678_9ABC_DEF0, 256'h1234_5678_9ABC_DEF0, '0);
    run_op("0mpm1", '0, P - 256'd1, 256'd1);
    run_op("pm1m0", P - 256'd1, '0, P - 256'd1);
    run_op("limb1", 256'd1 << 64, 256'd1, 256'hFFFF_FFFF_FFFF_FFFF);
    run_op("limb3", 256'd1 << 192, (256'd1 << 192) - 256'd1, 256'd1);

    // start held high: one done per 10 cycles, each using its own captured operands.
    @(negedge clk);
    a = 256'd100; b = 256'd40; start = 1'b1;
    @(posedge clk); #1;
    a = 256'd7; b = 256'd8;
    ndone = 0;
    for (int k = 0; k <= 28; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 10) begin a = 256'd50; b = 256'd50; end
      if (k == 20) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("hold_t1", word_t'(k), word_t'(9));
          check("hold_d1", diff, 256'd60);
        end else if (ndone == 2) begin
          check("hold_t2", word_t'(k), word_t'(19));
          check("hold_d2", diff, P - 256'd1);
        end
      end
    end
    check("hold_count", word_t'(ndone), word_t'(2));
    ndone = 0;
    for (int k = 0; k < 15 && ndone == 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone = 1;
        check("hold_d3", diff, '0);
      end
    end
    check("hold_d3_seen", word_t'(ndone), word_t'(1));

    // Reset mid-operation: abort, clear outputs, no done for the aborted op.
    @(negedge clk);
    a = 256'd3; b = 256'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_done", bit1(done), bit1(1'b0));
    check("abort_busy", bit1(busy), bit1(1'b0));
    check("abort_diff", diff, '0);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", word_t'(ndone), '0);
    run_op("9m4", 256'd9, 256'd4, 256'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gf_p_subtractor.md
Name: gf_p_subtractor

Overview:
- Limb-serial modular subtractor over GF(p), p = 2^255 − 19: computes diff = (a − b) mod p for 256-bit operands.
- Inverse companion of the team's GF(p) adder, sharing its 64-bit limb datapath style: one limb per cycle, then one conditional +p correction pass.
- Sits in the field-arithmetic unit beside the adder; driven by the point-arithmetic sequencer through a start/done handshake.

Parameters:
- WIDTH, 256, operand and result width in bits.
- LIMB_W, 64, bits processed per cycle; WIDTH must be a multiple of LIMB_W.
- NUM_LIMBS, WIDTH/LIMB_W (4), number of limb cycles per pass.
- MODULUS, 2^255 − 19 (0x7FFF…FFED), field prime p.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; required range 0..p−1.
- b  input  WIDTH  subtrahend; required range 0..p−1.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; diff is valid in that cycle.
- diff  output  WIDTH  registered result (a − b) mod p; holds until the next done.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: state = IDLE, busy = 0, done = 0, diff = 0, and all internal limb, borrow and carry registers = 0.
- States: IDLE → SUB → CORR → FIN → IDLE.
- IDLE:
  - start = 1 latches a and b into shift registers, clears borrow and carry, sets limb counter = 0, and moves to SUB.
  - start = 0 holds in IDLE.
- SUB (NUM_LIMBS cycles): limb i computes d_i = a_i − b_i − borrow (LSB limb first).
  - Store d_i and update borrow from the limb borrow-out.
  - On the last limb, latch final borrow into need_corr and go to CORR.
- CORR (NUM_LIMBS cycles, always executed, so latency is fixed):
  - Limb i computes c_i = d_i + p_i + carry; store c_i and update carry.
  - The final carry-out is discarded, so the sum is mod 2^WIDTH.
- FIN (1 cycle):
  - diff = need_corr ? c : d; done = 1; busy = 0; return to IDLE.
- Latency: start sampled at edge 0 → done high in the cycle after edge 9. Throughput is one operation per 10 cycles.
- busy = 1 in SUB and CORR.
- start while busy or in FIN is ignored; there is no queueing.
- Operands are captured at accept, so changes to a or b after that have no effect.
- Only one correction is applied. For in-range inputs, a − b + p is in 1..p−1 when a < b, so the result is always fully reduced. For out-of-range inputs, the result is defined only as (a − b [+ p if borrow]) mod 2^WIDTH.
- Reset asserted mid-operation aborts on the next edge:
  - IDLE, done = 0, busy = 0, diff = 0.
  - No done pulse is issued for the aborted operation.
- done is never asserted twice for one accepted start.

Decomposition:
- Shared package gf_p_pkg:
  - WIDTH, LIMB_W and NUM_LIMBS constants.
  - MODULUS constant (shared with the adder).
  - State enum {IDLE, SUB, CORR, FIN}.
- One sub-module, limb_addsub: 64-bit combinational adder/subtractor.
  - Inputs: mode (0 = add, 1 = sub), x, y, cin.
  - Outputs: r, cout (cout is carry-out for add, borrow-out for sub).
  - Instanced once and time-shared between SUB and CORR, with mode = 1 in SUB.

Test Plan:
- a=5, b=3, start pulse → done at cycle 10; diff = 2; busy high for cycles 1–8.
- a=3, b=5 → diff = p − 2 = 0x7FFF…FFEB (correction path taken).
- a=b=0x1234_5678_9ABC_DEF0 → diff = 0; a=0, b=p−1 → diff = 1.
- Cross-limb borrow: a=2^64, b=1 → diff = 0xFFFF_FFFF_FFFF_FFFF. Also a=2^192, b=2^192−1 → diff = 1.
- Hold start high through the operation with new a and b → exactly one done per 10 cycles, and each result matches the operands captured at accept.
- Assert reset at cycle 5 of an operation → next cycle: done = 0, busy = 0, diff = 0. A new start (a=9, b=4) then yields diff = 5 with no stale done.
